fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register. It sits directly upstream of the hazard detection unit.
- Owns the PC and issues requests to instruction memory, one outstanding request at a time.
- Presents fetched instructions to decode.
- Consumes `stall` from the hazard detection unit. Consumes redirects for taken branch/jal/jalr resolved downstream.

Parameters:
- XLEN, 32, width of PC and addresses.
- RESET_PC, 32'h00000000, first fetch address after reset.
- NOP_INSTR, 32'h00000013, value driven on ifid_instr while no valid instruction is present (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  from hazard detection unit; holds IF/ID contents.
- redirect  input  1  taken branch/jal/jalr; flushes wrong-path work.
- redirect_pc  input  XLEN  new fetch target, valid with redirect.
- imem_req  output  1  fetch request valid.
- imem_addr  output  XLEN  fetch address, equal to the PC register.
- imem_ready  input  1  memory accepts the request when imem_req && imem_ready.
- imem_rvalid  input  1  response valid; responses arrive in order, 1+ cycles after acceptance.
- imem_rdata  input  32  instruction word, valid with imem_rvalid.
- ifid_valid  output  1  IF/ID holds a real instruction.
- ifid_pc  output  XLEN  PC of the instruction in IF/ID.
- ifid_instr  output  32  instruction in IF/ID.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, state=REQ, buf_valid=0.
  - ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR.
- States:
  - REQ: no request outstanding.
  - WAIT: one request outstanding, response wanted.
  - KILL: one request outstanding, response to be discarded.
- imem_req = (state==REQ) && !buf_valid && !reset. imem_addr = pc.
- REQ, handshake accepted, no redirect: req_pc<=pc, pc<=pc+4 (mod 2^XLEN), state->WAIT.
- WAIT, imem_rvalid, no redirect: state->REQ.
  - If !stall: IF/ID <= {1, req_pc, imem_rdata}.
  - If stall: buf <= {req_pc, imem_rdata}, buf_valid<=1; IF/ID unchanged.
- IF/ID update when !stall and no redirect:
  - If buf_valid: IF/ID <= buf, buf_valid<=0.
  - Else if no response this cycle: ifid_valid<=0, ifid_instr<=NOP_INSTR (bubble); ifid_pc holds.
- stall=1 and no redirect: ifid_* hold all values; pc holds unless a handshake completes this cycle.
- buf_valid=1 blocks new requests. At most one instruction is buffered.
- Redirect (highest priority, overrides stall):
  - pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - ifid_valid<=0, ifid_instr<=NOP_INSTR, buf_valid<=0.
  - State update on redirect:
    - REQ with handshake accepted same cycle -> KILL.
    - REQ otherwise -> REQ.
    - WAIT without rvalid -> KILL.
    - WAIT with rvalid -> REQ (data dropped).
    - KILL without rvalid -> KILL.
    - KILL with rvalid -> REQ.
  - The redirected request is issued no earlier than the next cycle.
- KILL, imem_rvalid: discard data, state->REQ; IF/ID follows the bubble rules.
- imem_rvalid in REQ state is ignored (stray response after reset).
- Latency and throughput:
  - Accept at cycle N, rvalid at N+1 -> ifid_valid=1 visible at N+2.
  - Peak throughput is one instruction per 2 cycles with single-cycle memory.
- Reset mid-operation: outstanding request forgotten; memory side is reset by the same signal.

Test Plan:
- Reset release, imem_ready=1, rvalid one cycle after each accept, rdata=addr^32'hA5A5_0000 -> imem_addr sequence 0,4,8,C. ifid_pc/ifid_instr match with ifid_valid pulsing every other cycle; ifid_instr=NOP_INSTR in gaps.
- stall=1 for 4 cycles while response for PC 0x8 arrives -> IF/ID holds PC 0x4. Buffer captures 0x8 and imem_req stays 0. On stall release, ifid_pc=0x8 next cycle, then fetch of 0xC resumes.
- redirect with redirect_pc=0x103 one cycle after accepting a request to 0x10 -> state KILL and response for 0x10 discarded. Next request address is 0x100; ifid_valid=0 until 0x100 data arrives.
- redirect and stall asserted together while IF/ID and buffer are both valid -> ifid_valid=0 and buffer cleared next cycle. imem_addr = redirect target.
- imem_ready held 0 for 5 cycles -> imem_req stays 1 and imem_addr stable. PC must not increment; ifid_valid=0.
- Assert reset while in WAIT, then deliver a late rvalid after release -> response ignored; first fetch address is RESET_PC; all outputs at reset values.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// One request may be outstanding; responses return in order.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID register: owns the PC, keeps one imem request
// in flight, and parks a single response in a side buffer while decode is stalled.
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    fetch_unit_if.master    imem,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [31:0]     ifid_instr
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] pc_p0;
    logic [XLEN-1:0] req_pc_p0;
    logic [XLEN-1:0] buf_pc_p0;
    logic [31:0]     buf_instr_p0;
    logic            vld_buf_p0;
    logic            hs;
    logic            take;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

    function automatic logic [XLEN-1:0] incr_pc(input logic [XLEN-1:0] a);
        return a + XLEN'(4);
    endfunction

    assign imem.req  = (state_q == S_REQ) && !vld_buf_p0 && !reset;
    assign imem.addr = pc_p0;
    assign hs        = imem.req && imem.ready;
    // Only a WAIT-state response on the correct path is ever kept.
    assign take      = imem.rvalid && (state_q == S_WAIT) && !redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (hs) begin
                    state_d = redirect ? S_KILL : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.rvalid) begin
                    state_d = S_REQ;
                end else if (redirect) begin
                    state_d = S_KILL;
                end
            end
            S_KILL: begin
                if (imem.rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // IF stage: PC and side buffer control
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_p0      <= RESET_PC;
            vld_buf_p0 <= 1'b0;
        end else begin
            if (redirect) begin
                pc_p0 <= align_pc(redirect_pc);
            end else if (hs) begin
                pc_p0 <= incr_pc(pc_p0);
            end

            if (redirect) begin
                vld_buf_p0 <= 1'b0;
            end else if (stall) begin
                if (take) begin
                    vld_buf_p0 <= 1'b1;
                end
            end else begin
                vld_buf_p0 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            req_pc_p0 <= pc_p0;
        end
        if (take && stall) begin
            buf_pc_p0    <= req_pc_p0;
            buf_instr_p0 <= imem.rdata;
        end
    end

    // IF/ID boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
        end else if (redirect) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
        end else if (!stall) begin
            if (vld_buf_p0) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= buf_pc_p0;
                ifid_instr <= buf_instr_p0;
            end else if (take) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= req_pc_p0;
                ifid_instr <= imem.rdata;
            end else begin
                ifid_valid <= 1'b0;
                ifid_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory responder plus a queue-based model of
// the program-order instruction stream, compared every cycle on the falling edge.
module tb_fetch_unit;
    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;

    fetch_unit_if #(.XLEN(XLEN)) imem ();

    fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem(imem),
        .ifid_valid(ifid_valid),
        .ifid_pc(ifid_pc),
        .ifid_instr(ifid_instr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: next fetch address, the one in-flight request, and the
    // in-order queue of fetched-but-not-yet-presented instructions.
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_kill;
    logic [31:0] m_req_pc;
    int          m_lat;
    logic [63:0] dq[$];
    bit          m_vld;
    logic [31:0] m_ipc;
    logic [31:0] m_instr;

    int k_stall_pct = 0;
    int k_redir_pct = 0;
    int k_ready_pct = 100;
    int k_lat_max   = 0;
    int f_stall     = -1;
    int f_redir     = -1;
    int f_ready     = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc    = RPC;
        m_out   = 1'b0;
        m_kill  = 1'b0;
        m_lat   = 0;
        dq.delete();
        m_vld   = 1'b0;
        m_ipc   = '0;
        m_instr = NOP;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_req"}, imem.req, 0);
        chk({pfx, "_addr"}, imem.addr, RPC);
        chk({pfx, "_valid"}, ifid_valid, 0);
        chk({pfx, "_pc"}, ifid_pc, 0);
        chk({pfx, "_instr"}, ifid_instr, NOP);
    endtask

    function automatic bit pick(input int force_v, input int pct);
        if (force_v >= 0) return force_v[0];
        return $urandom_range(99) < pct;
    endfunction

    // Called on a falling edge; returns on the next falling edge.
    task automatic cycle(input bit stray);
        bit          exp_req, st, rd, rdy, rv, hs, resp;
        logic [31:0] rpc, data;
        logic [63:0] e;
        #1;
        exp_req = !m_out && (dq.size() == 0);
        chk("imem_req", imem.req, exp_req);
        chk("imem_addr", imem.addr, m_pc);
        chk("ifid_valid", ifid_valid, m_vld);
        chk("ifid_pc", ifid_pc, m_ipc);
        chk("ifid_instr", ifid_instr, m_instr);

        st   = pick(f_stall, k_stall_pct);
        rd   = pick(f_redir, k_redir_pct);
        rdy  = pick(f_ready, k_ready_pct);
        rpc  = $urandom;
        rv   = (m_out && m_lat == 0) || stray;
        data = m_out ? (m_req_pc ^ 32'hA5A5_0000) : $urandom;

        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem.ready  = rdy;
        imem.rvalid = rv;
        imem.rdata  = data;

        hs   = exp_req && rdy;
        resp = m_out && rv;
        if (resp) begin
            m_out = 1'b0;
            if (!m_kill && !rd) dq.push_back({m_req_pc, data});
        end else if (m_out) begin
            if (m_lat > 0) m_lat--;
            if (rd) m_kill = 1'b1;
        end
        if (rd) begin
            dq.delete();
            m_vld   = 1'b0;
            m_instr = NOP;
        end else if (!st) begin
            if (dq.size() != 0) begin
                e       = dq.pop_front();
                m_ipc   = e[63:32];
                m_instr = e[31:0];
                m_vld   = 1'b1;
            end else begin
                m_vld   = 1'b0;
                m_instr = NOP;
            end
        end
        if (hs) begin
            m_out    = 1'b1;
            m_kill   = rd;
            m_req_pc = m_pc;
            m_lat    = $urandom_range(k_lat_max);
            m_pc     = m_pc + 32'd4;
        end
        if (rd) m_pc = {rpc[31:2], 2'b00};

        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    initial begin
        imem.ready  = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = '0;
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("por");
        reset = 1'b0;

        // Back-to-back single-cycle memory: addresses 0,4,8,C...
        f_stall = 0; f_redir = 0; f_ready = 1; k_lat_max = 0;
        run(10);

        // Stall long enough for a response to land in the side buffer
        f_stall = 1;
        run(5);
        f_stall = 0;
        run(6);

        // Memory refuses requests
        f_ready = 0;
        run(5);
        f_ready = 1;
        run(4);

        // Broad random traffic
        f_stall = -1; f_redir = -1; f_ready = -1;
        k_stall_pct = 30; k_redir_pct = 8; k_ready_pct = 70; k_lat_max = 3;
        run(2000);
        k_stall_pct = 60; k_redir_pct = 15; k_ready_pct = 90; k_lat_max = 1;
        run(1000);

        // Reset while a request is outstanding, then a late stray response
        f_redir = 0; f_ready = 1; f_stall = 0; k_lat_max = 3;
        begin
            int budget = 50;
            while (!m_out && budget > 0) begin
                cycle(1'b0);
                budget--;
            end
            chk("wait_outstanding", m_out, 1);
        end
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        m_reset();
        imem.rvalid = 1'b1;
        imem.rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        #1;
        chk_reset_outputs("held_rst");
        reset = 1'b0;
        cycle(1'b1);
        run(6);

        f_stall = -1; f_redir = -1; f_ready = -1;
        k_stall_pct = 25; k_redir_pct = 5; k_ready_pct = 80; k_lat_max = 2;
        run(500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
